// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with RX FIFO and device-bus status/data registers
//
// Purpose: receives LSB-first 8N1 frames on uart_rx_i and samples each bit at mid-bit
//          using a baud counter derived from clk_i. Good bytes are buffered in an RX FIFO.
//          Data and status are read through a single-cycle request/response device bus.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   device_req_i       single-cycle bus request
//   device_addr_i      byte address, [11:0] decoded (0x0 RXDATA, 0x4 STATUS)
//   device_we_i        1 = write, 0 = read
//   device_be_i        byte enables, access acts only when be[0]=1
//   device_wdata_i     write data (STATUS W1C: bit1 frame_err, bit2 overflow)
//   device_rvalid_o    response, one cycle after every request
//   device_rdata_o     read data, valid with rvalid
//   uart_rx_i          asynchronous serial input, idle high
//   rx_irq_o           FIFO not empty or any sticky error set
module uart_rx #(
   parameter int ClockFrequency = 50_000_000,
   parameter int BaudRate       = 115_200,
   parameter int FifoDepth      = 64
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        device_req_i,
   input  logic [31:0] device_addr_i,
   input  logic        device_we_i,
   input  logic [3:0]  device_be_i,
   input  logic [31:0] device_wdata_i,
   output logic        device_rvalid_o,
   output logic [31:0] device_rdata_o,
   input  logic        uart_rx_i,
   output logic        rx_irq_o
);

   localparam int ClocksPerBaud = ClockFrequency / BaudRate;
   localparam int HalfBaud      = ClocksPerBaud / 2;
   localparam int CntW          = $clog2(ClocksPerBaud);
   localparam int AddrW         = $clog2(FifoDepth);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   // Input synchroniser and edge detector; preset high so reset looks like an idle line.
   logic r_sync1, r_sync2, r_rx_q;
   logic w_fall;

   state_t            r_state;
   logic [CntW-1:0]   r_cnt;
   logic [2:0]        r_bit_cnt;
   logic [7:0]        r_shift;
   logic              r_push;
   logic              r_frame_set;

   logic [7:0]        r_mem [FifoDepth];
   logic [AddrW:0]    r_wptr, r_rptr;
   logic              r_frame_err, r_overflow;
   logic              r_rvalid;
   logic [31:0]       r_rdata;

   logic              w_full, w_not_empty;
   logic              w_acc, w_pop, w_push_ok;
   logic              w_clr_frame, w_clr_ovf;
   logic [11:0]       w_reg_addr;
   logic [7:0]        w_head;
   logic [31:0]       w_rdata_next;
   logic              w_unused;

   assign w_fall = r_rx_q & ~r_sync2;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_rx_q  <= 1'b1;
      end else begin
         r_sync1 <= uart_rx_i;
         r_sync2 <= r_sync1;
         r_rx_q  <= r_sync2;
      end
   end

   // Receive FSM. The counter counts down to 0; it is reloaded at the start edge with a
   // half bit so every later sample lands mid-bit relative to that edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_push      <= 1'b0;
         r_frame_set <= 1'b0;
      end else begin
         r_push      <= 1'b0;
         r_frame_set <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_fall) begin
                  r_cnt   <= CntW'(HalfBaud - 1);
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (r_cnt == '0) begin
                  if (!r_sync2) begin
                     r_bit_cnt <= '0;
                     r_cnt     <= CntW'(ClocksPerBaud - 1);
                     r_state   <= S_DATA;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_DATA: begin
               if (r_cnt == '0) begin
                  r_shift <= {r_sync2, r_shift[7:1]};
                  r_cnt   <= CntW'(ClocksPerBaud - 1);
                  if (r_bit_cnt == 3'd7) begin
                     r_state <= S_STOP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_STOP: begin
               if (r_cnt == '0) begin
                  if (r_sync2) begin
                     r_push <= 1'b1;
                  end else begin
                     r_frame_set <= 1'b1;
                  end
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // FIFO status; pointers carry one extra wrap bit to tell full from empty.
   assign w_not_empty = (r_wptr != r_rptr);
   assign w_full      = (r_wptr[AddrW] != r_rptr[AddrW]) &&
                        (r_wptr[AddrW-1:0] == r_rptr[AddrW-1:0]);
   assign w_head      = r_mem[r_rptr[AddrW-1:0]];

   assign w_reg_addr  = device_addr_i[11:0];
   assign w_acc       = device_req_i & device_be_i[0];
   assign w_pop       = w_acc & ~device_we_i & (w_reg_addr == 12'h000) & w_not_empty;
   assign w_clr_frame = w_acc & device_we_i & (w_reg_addr == 12'h004) & device_wdata_i[1];
   assign w_clr_ovf   = w_acc & device_we_i & (w_reg_addr == 12'h004) & device_wdata_i[2];
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign w_push_ok   = r_push & (~w_full | w_pop);

   always_comb begin
      w_rdata_next = '0;
      if (w_acc && !device_we_i) begin
         case (w_reg_addr)
            12'h000: w_rdata_next = {23'b0, w_not_empty, (w_not_empty ? w_head : 8'h00)};
            12'h004: w_rdata_next = {28'b0, w_full, r_overflow, r_frame_err, w_not_empty};
            default: w_rdata_next = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_push_ok) begin
         r_mem[r_wptr[AddrW-1:0]] <= r_shift;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_frame_err <= 1'b0;
         r_overflow  <= 1'b0;
         r_rvalid    <= 1'b0;
         r_rdata     <= '0;
      end else begin
         if (w_push_ok) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         // Sticky errors: a set in the same cycle as a clear wins.
         if (r_frame_set) begin
            r_frame_err <= 1'b1;
         end else if (w_clr_frame) begin
            r_frame_err <= 1'b0;
         end
         if (r_push && !w_push_ok) begin
            r_overflow <= 1'b1;
         end else if (w_clr_ovf) begin
            r_overflow <= 1'b0;
         end
         r_rvalid <= device_req_i;
         r_rdata  <= w_rdata_next;
      end
   end

   assign device_rvalid_o = r_rvalid;
   assign device_rdata_o  = r_rdata;
   assign rx_irq_o        = w_not_empty | r_frame_err | r_overflow;

   assign w_unused = &{1'b0, device_addr_i[31:12], device_be_i[3:1],
                       device_wdata_i[31:3], device_wdata_i[0]};

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx against a queue-based receive model
module tb_uart_rx;

   localparam int CF    = 1_843_200;
   localparam int BR    = 115_200;
   localparam int DEPTH = 64;
   localparam int CPB   = CF / BR;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic [31:0] addr;
   logic        we;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        rvalid;
   logic [31:0] rdata;
   logic        rx;
   logic        irq;

   int checks = 0;
   int errors = 0;

   logic [7:0] model_q[$];
   bit         m_ferr;
   bit         m_ovf;

   always #5 clk = ~clk;

   uart_rx #(.ClockFrequency(CF), .BaudRate(BR), .FifoDepth(DEPTH)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .device_req_i    (req),
      .device_addr_i   (addr),
      .device_we_i     (we),
      .device_be_i     (be),
      .device_wdata_i  (wdata),
      .device_rvalid_o (rvalid),
      .device_rdata_o  (rdata),
      .uart_rx_i       (rx),
      .rx_irq_o        (irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic bus(input logic w, input logic [11:0] a, input logic [31:0] d,
                      input logic [3:0] b, output logic [31:0] r);
      @(negedge clk);
      req = 1'b1; we = w; addr = {20'hABCDE, a}; wdata = d; be = b;
      @(negedge clk);
      req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
      check("rvalid", {31'b0, rvalid}, 32'd1);
      r = rdata;
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok);
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_ok;
      repeat (CPB) @(negedge clk);
      if (!stop_ok) begin
         rx = 1'b1;
         repeat (CPB) @(negedge clk);
      end
   endtask

   // Reference: what a correct receiver does with one frame, in terms of the FIFO contents.
   task automatic model_frame(input logic [7:0] b, input bit stop_ok);
      if (!stop_ok) m_ferr = 1'b1;
      else if (model_q.size() == DEPTH) m_ovf = 1'b1;
      else model_q.push_back(b);
   endtask

   task automatic send(input logic [7:0] b, input bit stop_ok);
      send_frame(b, stop_ok);
      model_frame(b, stop_ok);
   endtask

   task automatic check_status(input string tag);
      logic [31:0] r;
      logic [31:0] exp;
      exp = {28'b0, model_q.size() == DEPTH, m_ovf, m_ferr, model_q.size() != 0};
      bus(1'b0, 12'h004, 32'h0, 4'hF, r);
      check(tag, r, exp);
      check({tag, "_irq"}, {31'b0, irq}, {31'b0, (model_q.size() != 0) | m_ferr | m_ovf});
   endtask

   task automatic read_expect(input string tag);
      logic [31:0] r;
      logic [31:0] exp;
      exp = (model_q.size() != 0) ? {23'b0, 1'b1, model_q.pop_front()} : 32'h0;
      bus(1'b0, 12'h000, 32'h0, 4'hF, r);
      check(tag, r, exp);
   endtask

   task automatic write_status(input logic [31:0] d, input logic [3:0] b);
      logic [31:0] r;
      bus(1'b1, 12'h004, d, b, r);
      check("wr_rdata", r, 32'h0);
      if (b[0]) begin
         if (d[1]) m_ferr = 1'b0;
         if (d[2]) m_ovf  = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] r;
      logic [7:0]  rb;
      bit          ok;
      rst_n = 1'b0; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0; rx = 1'b1;
      m_ferr = 1'b0; m_ovf = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_rvalid", {31'b0, rvalid}, 32'd0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'd0);
      rst_n = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check_status("idle_status");

      send(8'hA5, 1'b1);
      check_status("a5_status");
      read_expect("a5_read");
      read_expect("a5_read_empty");
      check_status("a5_status_after");

      send(8'h3C, 1'b0);
      check_status("ferr_status");
      write_status(32'h2, 4'h1);
      check_status("ferr_cleared");

      @(negedge clk);
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      check_status("glitch_status");
      send(8'h55, 1'b1);
      read_expect("after_glitch_55");

      for (int i = 0; i <= DEPTH; i++) send(8'(i), 1'b1);
      check_status("ovf_status");
      for (int i = 0; i < DEPTH; i++) read_expect("ovf_drain");
      read_expect("ovf_drain_empty");
      write_status(32'h4, 4'h1);
      check_status("ovf_cleared");

      send(8'h99, 1'b1);
      bus(1'b0, 12'h000, 32'h0, 4'h0, r);
      check("be0_read", r, 32'h0);
      check_status("be0_no_pop");
      read_expect("be0_then_read");
      send(8'hF0, 1'b0);
      write_status(32'h6, 4'h0);
      check_status("be0_no_clear");
      bus(1'b0, 12'h008, 32'h0, 4'hF, r);
      check("unmapped_read", r, 32'h0);
      write_status(32'h6, 4'h1);
      check_status("be0_cleared");

      for (int i = 0; i < 20; i++) begin
         rb = 8'($urandom);
         ok = ($urandom_range(0, 3) != 0);
         send(rb, ok);
      end
      check_status("rand_status");
      while (model_q.size() != 0) read_expect("rand_read");
      read_expect("rand_read_empty");
      write_status(32'h6, 4'h1);
      check_status("rand_cleared");

      send(8'h11, 1'b1);
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx = 1'(8'h81 >> i);
         repeat (CPB) @(negedge clk);
      end
      rx = 1'b0;
      repeat (CPB / 2) @(negedge clk);
      rst_n = 1'b0;
      rx = 1'b1;
      model_q.delete();
      m_ferr = 1'b0; m_ovf = 1'b0;
      repeat (CPB) @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * CPB) @(negedge clk);
      send(8'h7E, 1'b1);
      check_status("rst_mid_status");
      read_expect("rst_mid_7e");
      read_expect("rst_mid_empty");

      send(8'h48, 1'b1);
      send(8'h69, 1'b1);
      send(8'h0A, 1'b1);
      read_expect("hi_0");
      read_expect("hi_1");
      read_expect("hi_2");
      check_status("hi_done");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
